meter_countdown_ctrl: RTL and testbench

- Sequencing controller for the parking meter's time-remaining datapath.
- Takes one-cycle button/switch command pulses and 1 Hz / 2 Hz timebase pulses.
- Arbitrates simultaneous commands, updates a saturating seconds counter, and runs the NORMAL/LOW/EXPIRED display-mode FSM.
- Feeds the BCD/7-segment driver: a binary value and a display-enable (blink) signal.

---
 rtl/meter_countdown_ctrl.sv | 118 +++++++++++
 tb/tb_meter_countdown_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/meter_countdown_ctrl.sv
// rtl/meter_countdown_ctrl.sv - parking meter countdown sequencer with display-mode FSM and blink control
module meter_countdown_ctrl #(
  parameter int MAX_TIME   = 9999,
  parameter int LOW_THRESH = 180,
  parameter int ADD0       = 60,
  parameter int ADD1       = 120,
  parameter int ADD2       = 180,
  parameter int ADD3       = 300,
  parameter int PRESET0    = 10,
  parameter int PRESET1    = 205
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_1hz,
  input  logic        tick_2hz,
  input  logic [3:0]  add_p,
  input  logic [1:0]  preset_p,
  output logic [13:0] time_left,
  output logic [1:0]  mode,
  output logic        disp_on,
  output logic        expire_p
);

  localparam logic [1:0] MODE_NORMAL  = 2'b00;
  localparam logic [1:0] MODE_LOW     = 2'b01;
  localparam logic [1:0] MODE_EXPIRED = 2'b10;

  logic        phase;
  logic        blink_div;

  logic [13:0] time_nxt;
  logic [1:0]  mode_nxt;
  logic        expire_nxt;
  logic        phase_nxt;
  logic        div_nxt;
  logic        dec;
  logic [14:0] add_amt;
  logic [14:0] add_sum;

  // State register: counter, display mode, blink phase/divider and expiry pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      time_left <= '0;
      mode      <= MODE_EXPIRED;
      phase     <= 1'b1;
      blink_div <= 1'b0;
      expire_p  <= 1'b0;
    end else begin
      time_left <= time_nxt;
      mode      <= mode_nxt;
      phase     <= phase_nxt;
      blink_div <= div_nxt;
      expire_p  <= expire_nxt;
    end
  end

  // Next-state: arbitrate commands, update the saturating counter, derive mode and blink
  always_comb begin
    dec        = tick_1hz && (time_left != 14'd0);
    add_amt    = '0;
    add_sum    = '0;
    time_nxt   = time_left;
    expire_nxt = 1'b0;

    // Lowest-index add wins; losers in the same cycle are simply dropped.
    if (add_p[0])      add_amt = 15'(ADD0);
    else if (add_p[1]) add_amt = 15'(ADD1);
    else if (add_p[2]) add_amt = 15'(ADD2);
    else if (add_p[3]) add_amt = 15'(ADD3);

    if (preset_p[0]) begin
      time_nxt = 14'(PRESET0);
    end else if (preset_p[1]) begin
      time_nxt = 14'(PRESET1);
    end else if (add_p != 4'b0000) begin
      // Widened sum so that the saturation compare never sees a wrapped value.
      add_sum  = {1'b0, time_left} - {14'd0, dec} + add_amt;
      time_nxt = (add_sum > 15'(MAX_TIME)) ? 14'(MAX_TIME) : add_sum[13:0];
    end else begin
      time_nxt   = time_left - {13'd0, dec};
      expire_nxt = dec && (time_left == 14'd1);
    end

    if (time_nxt == 14'd0)                   mode_nxt = MODE_EXPIRED;
    else if (time_nxt < 14'(LOW_THRESH))     mode_nxt = MODE_LOW;
    else                                     mode_nxt = MODE_NORMAL;

    phase_nxt = phase;
    div_nxt   = blink_div;
    if (mode_nxt != mode) begin
      // Every mode change starts lit with a fresh divider.
      phase_nxt = 1'b1;
      div_nxt   = 1'b0;
    end else begin
      case (mode)
        MODE_LOW: begin
          if (tick_2hz) phase_nxt = ~phase;
        end
        MODE_EXPIRED: begin
          if (tick_2hz) begin
            div_nxt = ~blink_div;
            if (blink_div) phase_nxt = ~phase;
          end
        end
        default: begin
          phase_nxt = 1'b1;
          div_nxt   = 1'b0;
        end
      endcase
    end
  end

  // Output decode: NORMAL is always lit, other modes follow the blink phase
  always_comb begin
    disp_on = (mode == MODE_NORMAL) ? 1'b1 : phase;
  end

endmodule

// File: tb/tb_meter_countdown_ctrl.sv
// tb/tb_meter_countdown_ctrl.sv - directed self-checking bench for meter_countdown_ctrl
module tb_meter_countdown_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick_1hz;
  logic        tick_2hz;
  logic [3:0]  add_p;
  logic [1:0]  preset_p;
  logic [13:0] time_left;
  logic [1:0]  mode;
  logic        disp_on;
  logic        expire_p;

  int n_checks = 0;
  int n_errors = 0;

  meter_countdown_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_1hz (tick_1hz),
    .tick_2hz (tick_2hz),
    .add_p    (add_p),
    .preset_p (preset_p),
    .time_left(time_left),
    .mode     (mode),
    .disp_on  (disp_on),
    .expire_p (expire_p)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock with the given inputs applied, sampled 1ns after the edge
  task automatic step(input logic t1, input logic t2, input logic [3:0] a, input logic [1:0] p);
    @(negedge clk);
    tick_1hz = t1;
    tick_2hz = t2;
    add_p    = a;
    preset_p = p;
    @(posedge clk);
    #1;
    tick_1hz = 1'b0;
    tick_2hz = 1'b0;
    add_p    = 4'b0000;
    preset_p = 2'b00;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 4'b0000, 2'b00);
  endtask

  task automatic go_500();
    step(1'b0, 1'b0, 4'b0000, 2'b10);  // 205
    step(1'b0, 1'b0, 4'b1000, 2'b00);  // 505
    ticks(5);                          // 500
  endtask

  initial begin
    rst_n    = 1'b0;
    tick_1hz = 1'b0;
    tick_2hz = 1'b0;
    add_p    = 4'b0000;
    preset_p = 2'b00;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_time", time_left, 0);
    check("rst_mode", mode, 2);
    check("rst_disp", disp_on, 1);
    check("rst_exp", expire_p, 0);

    step(1'b0, 1'b1, 4'b0000, 2'b00);
    check("exp_blink_1st", disp_on, 1);
    step(1'b0, 1'b1, 4'b0000, 2'b00);
    check("exp_blink_2nd", disp_on, 0);

    // Add from expired then count into LOW
    step(1'b0, 1'b0, 4'b1000, 2'b00);
    check("add3_time", time_left, 300);
    check("add3_mode", mode, 0);
    check("add3_disp", disp_on, 1);
    ticks(121);
    check("low_time", time_left, 179);
    check("low_mode", mode, 1);
    check("low_disp", disp_on, 1);
    step(1'b0, 1'b1, 4'b0000, 2'b00);
    check("low_blink", disp_on, 0);

    // Expiry
    step(1'b0, 1'b0, 4'b0000, 2'b01);
    check("pre0_time", time_left, 10);
    ticks(9);
    check("pre_exp_time", time_left, 1);
    check("pre_exp_pulse", expire_p, 0);
    ticks(1);
    check("exp_time", time_left, 0);
    check("exp_pulse", expire_p, 1);
    check("exp_mode", mode, 2);
    step(1'b0, 1'b0, 4'b0000, 2'b00);
    check("exp_pulse_once", expire_p, 0);
    ticks(1);
    check("exp_hold_time", time_left, 0);
    check("exp_hold_pulse", expire_p, 0);

    // Saturation
    step(1'b0, 1'b0, 4'b0000, 2'b10);
    check("pre1_time", time_left, 205);
    for (int i = 0; i < 32; i++) step(1'b0, 1'b0, 4'b1000, 2'b00);
    check("sat_before", time_left, 9805);
    step(1'b0, 1'b0, 4'b1000, 2'b00);
    check("sat_ceiling", time_left, 9999);
    step(1'b0, 1'b0, 4'b0001, 2'b00);
    check("sat_hold", time_left, 9999);

    // Simultaneous events
    go_500();
    check("at_500", time_left, 500);
    step(1'b1, 1'b0, 4'b1111, 2'b01);
    check("preset_wins", time_left, 10);
    go_500();
    step(1'b1, 1'b0, 4'b0110, 2'b00);
    check("add1_with_tick", time_left, 619);
    step(1'b0, 1'b0, 4'b0000, 2'b01);
    ticks(9);
    check("at_1", time_left, 1);
    step(1'b1, 1'b0, 4'b0001, 2'b00);
    check("tick_add_time", time_left, 60);
    check("tick_add_noexp", expire_p, 0);
    check("tick_add_mode", mode, 1);

    // Async reset between edges
    step(1'b0, 1'b0, 4'b0000, 2'b01);
    step(1'b0, 1'b0, 4'b0001, 2'b00);
    step(1'b0, 1'b0, 4'b0100, 2'b00);
    check("at_250", time_left, 250);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_time", time_left, 0);
    check("arst_mode", mode, 2);
    check("arst_disp", disp_on, 1);
    check("arst_exp", expire_p, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b1, 4'b0000, 2'b00);
    check("arst_div_clear", disp_on, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
